// File: rtl/npu_layer_seq_if.sv
// -----------------------------------------------------------------------------
// npu_layer_seq_if
// Streaming bus bundle for the dense-layer sequencer.
//   IN_VALID / IN_READY : operand beat handshake (engine is the sink)
//   IN_A, IN_B          : N_CH signed operands each, lane i at [i*IN_W +: IN_W]
//   OUT_VALID/OUT_READY : result byte handshake (engine is the source)
//   OUT_DATA            : result byte
//   OUT_LAST            : final byte of the pass
// Modports:
//   master : the environment around the engine (feeds operands, drains bytes)
//   slave  : the engine itself
// -----------------------------------------------------------------------------
interface npu_layer_seq_if #(
    parameter int N_CH = 2,
    parameter int IN_W = 8
);
    logic                   IN_VALID;
    logic                   IN_READY;
    logic [N_CH*IN_W-1:0]   IN_A;
    logic [N_CH*IN_W-1:0]   IN_B;
    logic                   OUT_VALID;
    logic                   OUT_READY;
    logic [7:0]             OUT_DATA;
    logic                   OUT_LAST;

    modport master (
        output IN_VALID, IN_A, IN_B, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_DATA, OUT_LAST
    );

    modport slave (
        input  IN_VALID, IN_A, IN_B, OUT_READY,
        output IN_READY, OUT_VALID, OUT_DATA, OUT_LAST
    );
endinterface

// File: rtl/npu_layer_seq.sv
// -----------------------------------------------------------------------------
// npu_layer_seq
// Sequences one dense-layer pass over N_CH neuron lanes: bias preload,
// K_LEN-beat saturating multiply-accumulate, per-lane ReLU/bypass, argmax,
// then byte serialisation of all lane results (lane 0 first, MSB first).
// Ports:
//   CLKEXT       : clock
//   RST_GLO      : synchronous active-high reset (clears state, data, outputs)
//   START        : begin a pass, sampled only in IDLE
//   K_LEN        : number of MAC beats, captured at START
//   BIAS         : per-lane signed bias, lane i at [i*ACC_W +: ACC_W]
//   BYPASS_RELU  : per-lane ReLU bypass
//   bus          : operand stream in, result byte stream out (slave modport)
//   BUSY         : high in every state except IDLE and FINISH
//   DONE         : one-cycle pulse in FINISH
//   ARGMAX       : lowest index of the signed-largest activated result
//   MAX_VAL      : value of that result
// -----------------------------------------------------------------------------
module npu_layer_seq #(
    parameter int N_CH  = 2,
    parameter int IN_W  = 8,
    parameter int ACC_W = 16,
    parameter int IDX_W = 8
) (
    input  logic                    CLKEXT,
    input  logic                    RST_GLO,
    input  logic                    START,
    input  logic [7:0]              K_LEN,
    input  logic [N_CH*ACC_W-1:0]   BIAS,
    input  logic [N_CH-1:0]         BYPASS_RELU,
    npu_layer_seq_if.slave          bus,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [IDX_W-1:0]        ARGMAX,
    output logic [ACC_W-1:0]        MAX_VAL
);
    localparam int PW  = 2 * IN_W;
    localparam int TOT = N_CH * ACC_W;
    localparam int NB  = TOT / 8;
    localparam int BW  = $clog2(NB + 1);
    localparam logic [BW-1:0] LAST_B = BW'(NB - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_COMPUTE, S_ACT, S_SERIAL, S_FINISH
    } state_t;

    state_t                     state_q, state_d;
    logic [7:0]                 klen_q;
    logic [TOT-1:0]             bias_q;
    logic [N_CH-1:0]            byp_q;
    logic [7:0]                 cnt_q;
    logic signed [ACC_W-1:0]    acc_q [N_CH];
    logic [TOT-1:0]             ser_q;
    logic [BW-1:0]              bcnt_q;
    logic [IDX_W-1:0]           argmax_q;
    logic signed [ACC_W-1:0]    maxv_q;

    logic signed [ACC_W-1:0]    mac_w [N_CH];
    logic signed [ACC_W-1:0]    act_w [N_CH];
    logic [TOT-1:0]             ser_load;
    logic [IDX_W-1:0]           best_idx;
    logic signed [ACC_W-1:0]    best_val;

    logic in_ready, out_valid, out_last, busy, done;
    logic [7:0] out_data;

    // Full-precision signed product; operands are sign-extended first so the
    // multiply is evaluated at product width.
    function automatic logic signed [PW-1:0] mul(
        input logic signed [IN_W-1:0] a,
        input logic signed [IN_W-1:0] b
    );
        mul = PW'(a) * PW'(b);
    endfunction

    // Add in ACC_W+1 bits; the two top bits disagreeing means the true sum
    // left the ACC_W range, so clamp toward the sign of the wide result.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [PW-1:0]    p
    );
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {{(ACC_W + 1 - PW){p[PW-1]}}, p};
        if (!s[ACC_W] && s[ACC_W-1])
            sat_add = {1'b0, {(ACC_W - 1){1'b1}}};
        else if (s[ACC_W] && !s[ACC_W-1])
            sat_add = {1'b1, {(ACC_W - 1){1'b0}}};
        else
            sat_add = s[ACC_W-1:0];
    endfunction

    function automatic logic signed [ACC_W-1:0] relu(
        input logic signed [ACC_W-1:0] a,
        input logic                    byp
    );
        relu = (byp || !a[ACC_W-1]) ? a : '0;
    endfunction

    // Per-lane MAC candidates and activated values, argmax over activations.
    always_comb begin
        ser_load = '0;
        best_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            mac_w[i] = sat_add(acc_q[i],
                               mul($signed(bus.IN_A[i*IN_W +: IN_W]),
                                   $signed(bus.IN_B[i*IN_W +: IN_W])));
            act_w[i] = relu(acc_q[i], byp_q[i]);
            // Lane 0 sits at the top so a left shift emits it first.
            ser_load[TOT-1-i*ACC_W -: ACC_W] = act_w[i];
        end
        best_val = act_w[0];
        // Strict compare keeps the lowest index on ties.
        for (int i = 1; i < N_CH; i++) begin
            if (act_w[i] > best_val) begin
                best_val = act_w[i];
                best_idx = IDX_W'(i);
            end
        end
    end

    // State register
    always_ff @(posedge CLKEXT) begin
        if (RST_GLO)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START)
                    state_d = S_LOAD;
            end
            S_LOAD: begin
                busy    = 1'b1;
                state_d = (klen_q == 8'd0) ? S_ACT : S_COMPUTE;
            end
            S_COMPUTE: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (bus.IN_VALID && (cnt_q + 8'd1 == klen_q))
                    state_d = S_ACT;
            end
            S_ACT: begin
                busy    = 1'b1;
                state_d = S_SERIAL;
            end
            S_SERIAL: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = ser_q[TOT-1 -: 8];
                out_last  = (bcnt_q == LAST_B);
                if (bus.OUT_READY && out_last)
                    state_d = S_FINISH;
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Configuration capture, accumulation, activation and serialisation
    always_ff @(posedge CLKEXT) begin
        if (RST_GLO) begin
            klen_q   <= '0;
            bias_q   <= '0;
            byp_q    <= '0;
            cnt_q    <= '0;
            ser_q    <= '0;
            bcnt_q   <= '0;
            argmax_q <= '0;
            maxv_q   <= '0;
            for (int i = 0; i < N_CH; i++)
                acc_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        klen_q <= K_LEN;
                        bias_q <= BIAS;
                        byp_q  <= BYPASS_RELU;
                    end
                end
                S_LOAD: begin
                    cnt_q <= '0;
                    for (int i = 0; i < N_CH; i++)
                        acc_q[i] <= $signed(bias_q[i*ACC_W +: ACC_W]);
                end
                S_COMPUTE: begin
                    if (bus.IN_VALID) begin
                        cnt_q <= cnt_q + 8'd1;
                        for (int i = 0; i < N_CH; i++)
                            acc_q[i] <= mac_w[i];
                    end
                end
                S_ACT: begin
                    ser_q    <= ser_load;
                    bcnt_q   <= '0;
                    argmax_q <= best_idx;
                    maxv_q   <= best_val;
                end
                S_SERIAL: begin
                    if (bus.OUT_READY) begin
                        ser_q  <= ser_q << 8;
                        bcnt_q <= bcnt_q + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = out_valid;
    assign bus.OUT_DATA  = out_data;
    assign bus.OUT_LAST  = out_last;
    assign BUSY          = busy;
    assign DONE          = done;
    assign ARGMAX        = argmax_q;
    assign MAX_VAL       = maxv_q;
endmodule
